aes_iter_encrypt_core: RTL and testbench

//  Iterative AES encryption engine for AES-128, AES-192 and AES-256, selected by parameter. One shared round datapath runs one round per clock.
//  The block expands a loaded key once into round-key registers, then encrypts any number of blocks under that key.

---
 rtl/aes_iter_encrypt_core.sv | 205 ++++++++++++++++++++
 tb/tb_aes_iter_encrypt_core.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_encrypt_core.sv
// Iterative AES-128/192/256 encryptor: one shared round datapath (one round per clock)
// and an on-chip key expansion that fills round-key registers one word per clock.
module aes_iter_encrypt_core #(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key_in,
  output logic         key_ok,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   w_q [NW];
  logic [127:0]  blk_q, blk_d;
  logic [3:0]    rnd_q, rnd_d;
  logic [5:0]    idx_q, idx_d;
  logic [2:0]    kpos_q, kpos_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          key_ok_q, key_ok_d;
  logic          out_valid_q, out_valid_d;
  logic [127:0]  data_out_q, data_out_d;
  logic          key_ready_q, in_ready_q, busy_q;
  logic          w_load, w_step;
  logic          unused_key_bits;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  // Shorter keys ignore the low key_in bits.
  assign unused_key_bits = ^key_in;

  logic [3:0]   rk_idx;
  logic [127:0] rk;
  assign rk_idx = (state_q == ROUND) ? rnd_q : 4'd0;
  assign rk = {w_q[{rk_idx, 2'd0}], w_q[{rk_idx, 2'd1}], w_q[{rk_idx, 2'd2}], w_q[{rk_idx, 2'd3}]};

  logic [0:15][7:0] st_b, sh_b, mc_b;
  logic [127:0]     round_out;
  assign st_b = blk_q;

  // Byte at (row r, column c) takes the substituted byte from column (c+r) mod 4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
    assign sh_b[gi] = SBOX[st_b[4 * (((gi / 4) + (gi % 4)) % 4) + (gi % 4)]];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sh_b[4 * gi];
    assign a1 = sh_b[4 * gi + 1];
    assign a2 = sh_b[4 * gi + 2];
    assign a3 = sh_b[4 * gi + 3];
    assign mc_b[4 * gi]     = xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3;
    assign mc_b[4 * gi + 1] = xtime(a1 ^ a2) ^ a2 ^ a3 ^ a0;
    assign mc_b[4 * gi + 2] = xtime(a2 ^ a3) ^ a3 ^ a0 ^ a1;
    assign mc_b[4 * gi + 3] = xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2;
  end

  assign round_out = ((rnd_q == 4'(NR)) ? 128'(sh_b) : 128'(mc_b)) ^ rk;

  logic [31:0] w_prev, w_back, w_tmp, w_new;
  assign w_prev = w_q[idx_q - 6'd1];
  assign w_back = w_q[idx_q - 6'(NK)];

  // kpos tracks i mod Nk so no divider is needed for the word-type decision.
  always_comb begin
    w_tmp = w_prev;
    if (kpos_q == 3'd0) begin
      w_tmp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'd0};
    end else if (NK == 8 && kpos_q == 3'd4) begin
      w_tmp = sub_word(w_prev);
    end
  end
  assign w_new = w_back ^ w_tmp;

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    rnd_d       = rnd_q;
    idx_d       = idx_q;
    kpos_d      = kpos_q;
    rcon_d      = rcon_q;
    key_ok_d    = key_ok_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          w_load   = 1'b1;
          key_ok_d = 1'b0;
          idx_d    = 6'(NK);
          kpos_d   = 3'd0;
          rcon_d   = 8'h01;
          state_d  = KEXP;
        end else if (in_valid && key_ok_q) begin
          blk_d   = data_in ^ rk;
          rnd_d   = 4'd1;
          state_d = ROUND;
        end
      end
      KEXP: begin
        w_step = 1'b1;
        idx_d  = idx_q + 6'd1;
        kpos_d = (kpos_q == 3'(NK - 1)) ? 3'd0 : kpos_q + 3'd1;
        if (kpos_q == 3'd0) rcon_d = xtime(rcon_q);
        if (idx_q == 6'(NW - 1)) begin
          key_ok_d = 1'b1;
          state_d  = IDLE;
        end
      end
      ROUND: begin
        blk_d = round_out;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'(NR)) begin
          data_out_d  = round_out;
          out_valid_d = 1'b1;
          rnd_d       = 4'd0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      rnd_q       <= '0;
      idx_q       <= '0;
      kpos_q      <= '0;
      rcon_q      <= '0;
      key_ok_q    <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      key_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      rnd_q       <= rnd_d;
      idx_q       <= idx_d;
      kpos_q      <= kpos_d;
      rcon_q      <= rcon_d;
      key_ok_q    <= key_ok_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      key_ready_q <= (state_d == IDLE);
      in_ready_q  <= (state_d == IDLE) && key_ok_d;
      busy_q      <= (state_d == KEXP) || (state_d == ROUND);
      for (int k = 0; k < NK; k++) begin
        if (w_load) w_q[k] <= key_in[255 - 32 * k -: 32];
      end
      for (int k = 0; k < NW; k++) begin
        if (w_step && idx_q == 6'(k)) w_q[k] <= w_new;
      end
    end
  end

  assign key_ready = key_ready_q;
  assign key_ok    = key_ok_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_aes_iter_encrypt_core.sv
// Scoreboard bench for aes_iter_encrypt_core: one instance per key size, each checked
// against a table-free AES model (S-box derived from GF(2^8) inversion).
module tb_aes_iter_encrypt_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  initial begin
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [127:0] ref_enc(input logic [255:0] key, input int nk, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i - 1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i - nk] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127 - 8 * k -: 8] ^ w[k / 4][31 - 8 * (k % 4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sb[s[4 * ((k / 4 + k % 4) % 4) + k % 4]];
      for (int k = 0; k < 16; k++) begin
        if (r == nr) s[k] = t[k];
        else s[k] = gmul(8'h02, t[k]) ^ gmul(8'h03, t[4 * (k / 4) + (k % 4 + 1) % 4])
                    ^ t[4 * (k / 4) + (k % 4 + 2) % 4] ^ t[4 * (k / 4) + (k % 4 + 3) % 4];
        s[k] ^= w[4 * r + k / 4][31 - 8 * (k % 4) -: 8];
      end
    end
    for (int k = 0; k < 16; k++) res[127 - 8 * k -: 8] = s[k];
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic mark_done();
    done_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int KB = 128 + 64 * gi;
    localparam int NK = KB / 32;
    localparam int NR = NK + 6;
    localparam int KEXP_CYC = 4 * (NR + 1) - NK;
    localparam logic [255:0] KAT_KEY = (gi == 0) ? {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0} :
      (gi == 1) ? {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0} :
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KAT_PT = (gi == 0) ? 128'h3243f6a8885a308d313198a2e0370734 :
      128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT = (gi == 0) ? 128'h3925841d02dc09fbdc118597196a0b32 :
      (gi == 1) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 : 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         rst_n, key_valid, key_ready, key_ok, in_valid, in_ready;
    logic         out_valid, out_ready, busy;
    logic [255:0] key_in;
    logic [127:0] data_in, data_out;
    logic [127:0] exp_q [$];
    logic         rand_mode = 1'b0;
    logic         ready_force = 1'b1;

    aes_iter_encrypt_core #(.KEY_BITS(KB)) dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
      .key_ok(key_ok), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
    );

    function automatic string nm(input string s);
      return $sformatf("k%0d_%s", KB, s);
    endfunction

    always @(posedge clk) begin
      #1;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end

    always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL %s: got %h, expected no output", nm("unexpected_out"), data_out);
        end else begin
          check(nm("ciphertext"), data_out, exp_q.pop_front());
        end
      end
    end

    task automatic load_key(input logic [255:0] k);
      int n;
      n = 0;
      key_in = k;
      key_valid = 1'b1;
      while (!key_ready && n < 300) begin tick(); n++; end
      if (!key_ready) begin timeout_fail(nm("key_ready_wait")); key_valid = 1'b0; return; end
      tick();
      key_valid = 1'b0;
      check(nm("kexp_start"), 128'({busy, key_ok, in_ready}), 128'(3'b100));
      n = 0;
      while (!key_ok && n < 200) begin tick(); n++; end
      check(nm("kexp_cycles"), 128'(n), 128'(KEXP_CYC));
    endtask

    task automatic send_block(input logic [127:0] pt, input logic [127:0] ct, input bit meas);
      int n;
      n = 0;
      data_in = pt;
      in_valid = 1'b1;
      while (!in_ready && n < 300) begin tick(); n++; end
      if (!in_ready) begin timeout_fail(nm("in_ready_wait")); in_valid = 1'b0; return; end
      exp_q.push_back(ct);
      tick();
      in_valid = 1'b0;
      if (meas) begin
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        check(nm("latency"), 128'(n), 128'(NR));
      end
    endtask

    initial begin
      logic [255:0] key2;
      logic [127:0] pt, pt2, hold;
      bit ok;
      int n;
      rst_n = 1'b1; key_valid = 1'b0; in_valid = 1'b0; key_in = '0; data_in = '0;
      #2 rst_n = 1'b0;
      repeat (3) tick();
      check(nm("reset_flags"), 128'({key_ready, key_ok, in_ready, out_valid, busy}), 128'(5'b10000));
      check(nm("reset_data_out"), data_out, 128'h0);
      rst_n = 1'b1;
      tick();

      // Block offered before any key: must be refused.
      data_in = KAT_PT;
      in_valid = 1'b1;
      repeat (5) tick();
      check(nm("nokey_refused"), 128'({busy, in_ready, out_valid, key_ok}), 128'(4'b0000));

      // Key arrives while the block is still offered; key wins, block follows after key_ok.
      load_key(KAT_KEY);
      send_block(KAT_PT, KAT_CT, 1'b1);

      // Backpressure: result holds, nothing else accepted.
      ready_force = 1'b0;
      pt = rand128();
      send_block(pt, ref_enc(KAT_KEY, NK, pt), 1'b0);
      n = 0;
      while (!out_valid && n < 100) begin tick(); n++; end
      hold = data_out;
      pt2 = rand128();
      data_in = pt2;
      in_valid = 1'b1;
      ok = 1'b1;
      repeat (20) begin
        tick();
        if (data_out !== hold || !out_valid || in_ready || busy) ok = 1'b0;
      end
      check(nm("backpressure_hold"), 128'(ok), 128'(1));
      ready_force = 1'b1;
      send_block(pt2, ref_enc(KAT_KEY, NK, pt2), 1'b0);

      rand_mode = 1'b1;
      repeat (6) begin
        pt = rand128();
        send_block(pt, ref_enc(KAT_KEY, NK, pt), 1'b0);
      end

      // Collision with a valid key loaded: new key wins and the block waits for it.
      key2 = {rand128(), rand128()};
      pt = rand128();
      data_in = pt;
      in_valid = 1'b1;
      load_key(key2);
      send_block(pt, ref_enc(key2, NK, pt), 1'b0);
      repeat (4) begin
        pt = rand128();
        send_block(pt, ref_enc(key2, NK, pt), 1'b0);
      end

      // Reset while rnd == 5 abandons the block and the key.
      rand_mode = 1'b0;
      ready_force = 1'b1;
      pt = rand128();
      send_block(pt, ref_enc(key2, NK, pt), 1'b0);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check(nm("midround_reset_flags"), 128'({key_ready, key_ok, in_ready, out_valid, busy}), 128'(5'b10000));
      check(nm("midround_reset_data"), data_out, 128'h0);
      if (exp_q.size() != 0) void'(exp_q.pop_back());
      tick();
      rst_n = 1'b1;
      tick();
      load_key(KAT_KEY);
      send_block(KAT_PT, KAT_CT, 1'b1);

      n = 0;
      while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
      if (exp_q.size() != 0) timeout_fail(nm("drain"));
      mark_done();
    end
  end

  initial begin
    int t;
    t = 0;
    while (done_cnt < 3 && t < 60000) begin @(posedge clk); t++; end
    if (done_cnt < 3) timeout_fail("global_run");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
